// File: rtl/calc1_pkg.sv
// Shared calc1 definitions: command/response codes, bus widths and the port-driver state type.
package calc1_pkg;

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RESP_W = 2;

  localparam logic [0:CMD_W-1] CMD_NOP = 4'd0;
  localparam logic [0:CMD_W-1] CMD_ADD = 4'd1;
  localparam logic [0:CMD_W-1] CMD_SUB = 4'd2;
  localparam logic [0:CMD_W-1] CMD_SHL = 4'd5;
  localparam logic [0:CMD_W-1] CMD_SHR = 4'd6;

  localparam logic [0:RESP_W-1] RESP_NONE = 2'd0;
  localparam logic [0:RESP_W-1] RESP_OK   = 2'd1;
  localparam logic [0:RESP_W-1] RESP_ERR  = 2'd2;
  localparam logic [0:RESP_W-1] RESP_RSVD = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StSendOp1,
    StSendOp2,
    StWaitResp,
    StResult
  } drv_state_e;

  function automatic logic is_nop(input logic [0:CMD_W-1] cmd);
    return cmd == CMD_NOP;
  endfunction

endpackage

// File: rtl/calc1_drv_timer.sv
// Load/count/expire down-counter bounding how long the port driver waits for a calc1 response.
module calc1_drv_timer #(
  parameter int unsigned CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_count,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(CYCLES);
  localparam logic [CntW-1:0] LoadVal = CntW'(CYCLES - 1);

  logic [CntW-1:0] r_cnt;

  // Loaded with CYCLES-1 so expiry is flagged during the CYCLES-th counted cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LoadVal;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/calc1_port_driver.sv
// Serialises one operation onto a calc1 request port and returns its response.
// Optional response timeout enabled by defining CALC1_DRV_TIMEOUT_EN.
module calc1_port_driver
  import calc1_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [0:CMD_W-1]  op_cmd,
  input  logic [0:DATA_W-1] op_a,
  input  logic [0:DATA_W-1] op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [0:RESP_W-1] res_resp,
  output logic [0:DATA_W-1] res_data,
  output logic              res_timeout,
  output logic              busy,
  output logic [0:CMD_W-1]  req_cmd_out,
  output logic [0:DATA_W-1] req_data_out,
  input  logic [0:RESP_W-1] out_resp,
  input  logic [0:DATA_W-1] out_data
);

  drv_state_e r_state, w_state_nxt;

  logic              w_accept;
  logic              w_resp_hit;
  logic              w_timeout;
  logic [0:DATA_W-1] r_op_b;

  logic              r_op_ready, w_op_ready_d;
  logic              r_busy, w_busy_d;
  logic [0:CMD_W-1]  r_req_cmd, w_req_cmd_d;
  logic [0:DATA_W-1] r_req_data, w_req_data_d;
  logic              r_res_valid, w_res_valid_d;
  logic [0:RESP_W-1] r_res_resp, w_res_resp_d;
  logic [0:DATA_W-1] r_res_data, w_res_data_d;
  logic              r_res_timeout, w_res_timeout_d;

  assign w_accept   = op_valid && r_op_ready && (r_state == StIdle);
  // Responses outside WAIT_RESP are strays and never reach the result path.
  assign w_resp_hit = (r_state == StWaitResp) && (out_resp != RESP_NONE);

`ifdef CALC1_DRV_TIMEOUT_EN
  logic w_tmr_expired;

  calc1_drv_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (c_clk),
    .i_reset  (reset),
    .i_load   (r_state == StSendOp2),
    .i_count  (r_state == StWaitResp),
    .o_expired(w_tmr_expired)
  );

  assign w_timeout = (r_state == StWaitResp) && w_tmr_expired && !w_resp_hit;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign w_timeout            = 1'b0;
`endif

  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_nxt = is_nop(op_cmd) ? StResult : StSendOp1;
        end
      end
      StSendOp1:  w_state_nxt = StSendOp2;
      StSendOp2:  w_state_nxt = StWaitResp;
      StWaitResp: begin
        if (w_resp_hit || w_timeout) begin
          w_state_nxt = StResult;
        end
      end
      StResult: begin
        if (res_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Next values of the registered outputs, decoded from the state being entered.
  always_comb begin
    w_op_ready_d    = (w_state_nxt == StIdle);
    w_busy_d        = (w_state_nxt != StIdle);
    w_req_cmd_d     = CMD_NOP;
    w_req_data_d    = '0;
    w_res_valid_d   = (w_state_nxt == StResult);
    w_res_resp_d    = RESP_NONE;
    w_res_data_d    = '0;
    w_res_timeout_d = 1'b0;

    if (w_accept && !is_nop(op_cmd)) begin
      w_req_cmd_d  = op_cmd;
      w_req_data_d = op_a;
    end else if (r_state == StSendOp1) begin
      w_req_data_d = r_op_b;
    end

    if (w_state_nxt == StResult) begin
      if (r_state == StResult) begin
        w_res_resp_d    = r_res_resp;
        w_res_data_d    = r_res_data;
        w_res_timeout_d = r_res_timeout;
      end else if (w_resp_hit) begin
        w_res_resp_d = out_resp;
        w_res_data_d = out_data;
      end else if (w_timeout) begin
        w_res_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_op_b        <= '0;
      r_op_ready    <= 1'b0;
      r_busy        <= 1'b0;
      r_req_cmd     <= CMD_NOP;
      r_req_data    <= '0;
      r_res_valid   <= 1'b0;
      r_res_resp    <= RESP_NONE;
      r_res_data    <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op_b <= op_b;
      end
      r_op_ready    <= w_op_ready_d;
      r_busy        <= w_busy_d;
      r_req_cmd     <= w_req_cmd_d;
      r_req_data    <= w_req_data_d;
      r_res_valid   <= w_res_valid_d;
      r_res_resp    <= w_res_resp_d;
      r_res_data    <= w_res_data_d;
      r_res_timeout <= w_res_timeout_d;
    end
  end

  assign op_ready     = r_op_ready;
  assign busy         = r_busy;
  assign req_cmd_out  = r_req_cmd;
  assign req_data_out = r_req_data;
  assign res_valid    = r_res_valid;
  assign res_resp     = r_res_resp;
  assign res_data     = r_res_data;
  assign res_timeout  = r_res_timeout;

endmodule

// File: tb/tb_calc1_port_driver.sv
// Self-checking bench for calc1_port_driver: cycle-indexed transaction model plus directed literals.
module tb_calc1_port_driver;

  localparam int unsigned TMO = 8;

  logic        c_clk     = 1'b0;
  logic        reset     = 1'b1;
  logic        op_valid  = 1'b0;
  logic        res_ready = 1'b0;
  logic [0:3]  op_cmd    = '0;
  logic [0:31] op_a      = '0;
  logic [0:31] op_b      = '0;
  logic [0:1]  out_resp  = '0;
  logic [0:31] out_data  = '0;

  logic        op_ready, res_valid, res_timeout, busy;
  logic [0:1]  res_resp;
  logic [0:31] res_data, req_data_out;
  logic [0:3]  req_cmd_out;

  int n_tests = 0;
  int n_fail  = 0;

  calc1_port_driver #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_cmd      (op_cmd),
    .op_a        (op_a),
    .op_b        (op_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_resp    (res_resp),
    .res_data    (res_data),
    .res_timeout (res_timeout),
    .busy        (busy),
    .req_cmd_out (req_cmd_out),
    .req_data_out(req_data_out),
    .out_resp    (out_resp),
    .out_data    (out_data)
  );

  always #5 c_clk = ~c_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: remembers the edge an operation was accepted on and derives the
  // bus contents, response window and result from cycle arithmetic.
  int          m_edge     = 0;
  int          m_acc      = 0;
  logic        m_started  = 1'b0;
  logic        m_ready    = 1'b0;
  logic        m_inflight = 1'b0;
  logic        m_rv       = 1'b0;
  logic        m_tmo      = 1'b0;
  logic [0:1]  m_resp     = '0;
  logic [0:3]  m_cmd      = '0;
  logic [0:31] m_a        = '0;
  logic [0:31] m_b        = '0;
  logic [0:31] m_data     = '0;

  always @(posedge c_clk) begin
    m_edge    <= m_edge + 1;
    m_started <= 1'b1;
    if (reset) begin
      m_ready    <= 1'b0;
      m_inflight <= 1'b0;
      m_rv       <= 1'b0;
      m_resp     <= '0;
      m_data     <= '0;
      m_tmo      <= 1'b0;
    end else if (m_rv) begin
      if (res_ready) begin
        m_rv       <= 1'b0;
        m_resp     <= '0;
        m_data     <= '0;
        m_tmo      <= 1'b0;
        m_inflight <= 1'b0;
        m_ready    <= 1'b1;
      end
    end else if (!m_inflight) begin
      m_ready <= 1'b1;
      if (m_ready && op_valid) begin
        m_ready    <= 1'b0;
        m_inflight <= 1'b1;
        m_acc      <= m_edge;
        m_cmd      <= op_cmd;
        m_a        <= op_a;
        m_b        <= op_b;
        if (op_cmd == 4'd0) m_rv <= 1'b1;
      end
    end else if (m_edge >= m_acc + 3) begin
      if (out_resp != 2'd0) begin
        m_rv   <= 1'b1;
        m_resp <= out_resp;
        m_data <= out_data;
      end
`ifdef CALC1_DRV_TIMEOUT_EN
      else if (m_edge - m_acc - 2 == int'(TMO)) begin
        m_rv  <= 1'b1;
        m_tmo <= 1'b1;
      end
`endif
    end
  end

  always @(negedge c_clk) begin
    if (m_started) begin
      logic        on_bus1, on_bus2;
      on_bus1 = m_inflight && (m_cmd != 4'd0) && (m_edge == m_acc + 1);
      on_bus2 = m_inflight && (m_cmd != 4'd0) && (m_edge == m_acc + 2);
      check("op_ready", op_ready, m_ready);
      check("busy", busy, m_inflight);
      check("req_cmd_out", req_cmd_out, on_bus1 ? m_cmd : 4'd0);
      check("req_data_out", req_data_out, on_bus1 ? m_a : (on_bus2 ? m_b : 32'd0));
      check("res_valid", res_valid, m_rv);
      check("res_resp", res_resp, m_resp);
      check("res_data", res_data, m_data);
      check("res_timeout", res_timeout, m_tmo);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge c_clk);
      #2;
    end
  endtask

  task automatic present(input logic [0:3] c, input logic [0:31] a, input logic [0:31] b);
    op_valid = 1'b1;
    op_cmd   = c;
    op_a     = a;
    op_b     = b;
  endtask

  task automatic respond(input logic [0:1] r, input logic [0:31] d);
    out_resp = r;
    out_data = d;
    tick(1);
    out_resp = '0;
    out_data = '0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick(1);
    res_ready = 1'b0;
  endtask

  initial begin
    tick(3);
    check("lit reset op_ready", op_ready, 0);
    check("lit reset busy", busy, 0);
    check("lit reset req_data", req_data_out, 0);
    reset = 1'b0;
    tick(1);
    check("lit op_ready after reset", op_ready, 1);

    respond(2'd1, 32'hFFFF_FFFF);
    check("lit idle stray res_valid", res_valid, 0);

    // ADD: response three cycles after the op2 cycle
    present(4'd1, 32'h0000_0001, 32'h1FFF_FFFF);
    tick(1);
    op_valid = 1'b0;
    check("lit add cmd", req_cmd_out, 1);
    check("lit add op1", req_data_out, 32'h0000_0001);
    check("lit add op_ready", op_ready, 0);
    tick(1);
    check("lit add nop", req_cmd_out, 0);
    check("lit add op2", req_data_out, 32'h1FFF_FFFF);
    tick(3);
    respond(2'd1, 32'h2000_0000);
    check("lit add res_valid", res_valid, 1);
    check("lit add res_resp", res_resp, 1);
    check("lit add res_data", res_data, 32'h2000_0000);
    tick(2);
    handshake();
    check("lit add op_ready back", op_ready, 1);

    // Backpressure with a second operation already waiting
    present(4'd1, 32'd5, 32'd7);
    tick(1);
    present(4'd2, 32'd9, 32'd4);
    tick(2);
    respond(2'd1, 32'd12);
    for (int i = 0; i < 5; i++) begin
      check("lit bp res_data", res_data, 32'd12);
      check("lit bp op_ready", op_ready, 0);
      tick(1);
    end
    handshake();
    check("lit bp op_ready after hs", op_ready, 1);
    check("lit bp no accept at hs", req_cmd_out, 0);
    tick(1);
    op_valid = 1'b0;
    check("lit bp second cmd", req_cmd_out, 2);
    check("lit bp second op1", req_data_out, 32'd9);
    tick(2);
    respond(2'd1, 32'd5);
    check("lit bp second data", res_data, 32'd5);
    handshake();

    // NOP: no bus activity, immediate zero result
    present(4'd0, 32'hDEAD_0000, 32'h0000_BEEF);
    tick(1);
    op_valid = 1'b0;
    check("lit nop res_valid", res_valid, 1);
    check("lit nop req_cmd", req_cmd_out, 0);
    check("lit nop req_data", req_data_out, 0);
    handshake();

    // Error responses are passed through unchanged
    present(4'd2, 32'd1, 32'd15);
    tick(1);
    op_valid = 1'b0;
    tick(2);
    respond(2'd2, 32'd0);
    check("lit sub err resp", res_resp, 2);
    handshake();
    present(4'd3, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    tick(1);
    op_valid = 1'b0;
    check("lit invalid cmd passthru", req_cmd_out, 3);
    tick(3);
    respond(2'd2, 32'd0);
    check("lit invalid cmd resp", res_resp, 2);
    handshake();

    // Reset during WAIT_RESP; the late response must be dropped
    present(4'd5, 32'h10, 32'd2);
    tick(1);
    op_valid = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("lit rst busy", busy, 0);
    check("lit rst op_ready", op_ready, 0);
    check("lit rst res_valid", res_valid, 0);
    tick(1);
    respond(2'd1, 32'h40);
    check("lit late resp dropped", res_valid, 0);
    check("lit late resp op_ready", op_ready, 1);

`ifdef CALC1_DRV_TIMEOUT_EN
    present(4'd6, 32'd3, 32'd4);
    tick(1);
    op_valid = 1'b0;
    tick(9);
    check("lit tmo not yet", res_valid, 0);
    tick(1);
    check("lit tmo res_valid", res_valid, 1);
    check("lit tmo flag", res_timeout, 1);
    check("lit tmo resp", res_resp, 0);
    handshake();
    respond(2'd1, 32'h99);
    check("lit tmo late resp", res_valid, 0);
`endif

    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
